branch_tag_queue: RTL and testbench

Parametrised in-order tag allocator and recovery store for in-flight branches and JALRs, sitting between fetch and the execute/branch-resolution path. Fetch allocates a tag per predicted control instruction and saves its recovery PC. Execute resolves tags in any order. A mispredict produces a one-cycle redirect PC and squashes every younger tag. Successor to the fixed 8-entry head/tail arrays in fetch; adds depth parametrisation, out-of-order resolution, partial (younger-only) squash and backpressure.

---
 rtl/branch_tag_queue.sv | 147 ++++++++++++++
 tb/tb_branch_tag_queue.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_tag_queue.sv
// In-order tag allocator and recovery-PC store for in-flight branches/JALRs with
// out-of-order resolve, younger-only squash and one-cycle redirect. Optional: BTQ_STATS_EN.
module branch_tag_queue #(
  parameter  int DEPTH = 8,
  parameter  int XLEN  = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alloc_valid,
  input  logic             alloc_is_jalr,
  input  logic [XLEN-1:0]  alloc_recovery_pc,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             resolve_valid,
  input  logic [TAG_W-1:0] resolve_tag,
  input  logic             resolve_mispredict,
  input  logic [XLEN-1:0]  resolve_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [TAG_W:0]   occupancy,
  output logic             empty
`ifdef BTQ_STATS_EN
  ,
  output logic [31:0]      stat_resolved,
  output logic [31:0]      stat_mispredict
`endif
);

  localparam logic [TAG_W:0] PTR_ONE = (TAG_W+1)'(1);
  localparam logic [TAG_W:0] FULL_X  = {1'b1, {TAG_W{1'b0}}};

  logic [TAG_W:0]     head_q, head_d, tail_q, tail_d, occ;
  logic [DEPTH-1:0]   valid_q, valid_d, resolved_q, resolved_d, is_jalr_q;
  logic [XLEN-1:0]    pc_q [DEPTH];
  logic               redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]    redirect_pc_q, redirect_pc_d;
  logic [TAG_W-1:0]   head_idx, tail_idx, dist_t;
  logic               full, rs_live, rs_accept, mp_accept, alloc_fire, retire;

  assign head_idx  = head_q[TAG_W-1:0];
  assign tail_idx  = tail_q[TAG_W-1:0];
  assign occ       = tail_q - head_q;
  assign full      = (head_q ^ tail_q) == FULL_X;
  assign rs_live   = valid_q[resolve_tag];
  assign rs_accept = resolve_valid && rs_live && !resolved_q[resolve_tag];
  assign mp_accept = rs_accept && resolve_mispredict;
  // Any mispredict naming a live tag blocks allocation, even one ignored as already resolved.
  assign alloc_ready = !full && !(resolve_valid && resolve_mispredict && rs_live)
                       && !redirect_valid_q;
  assign alloc_fire  = alloc_valid && alloc_ready;
  // Uses registered state only, so a head resolved this cycle retires next cycle.
  assign retire      = valid_q[head_idx] && resolved_q[head_idx];
  assign dist_t      = resolve_tag - head_idx;

  // NOTE: every _d starts from its _q so no path leaves a variable unassigned (no latch).
  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    valid_d          = valid_q;
    resolved_d       = resolved_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;

    if (retire) begin
      valid_d[head_idx]    = 1'b0;
      resolved_d[head_idx] = 1'b0;
      head_d               = head_q + PTR_ONE;
    end
    if (rs_accept) resolved_d[resolve_tag] = 1'b1;
    if (mp_accept) begin
      // Squash by modular age from head; slots past the tail are already invalid.
      for (int i = 0; i < DEPTH; i++) begin
        if (TAG_W'(TAG_W'(i) - head_idx) > dist_t) begin
          valid_d[i]    = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      tail_d           = head_q + {1'b0, dist_t} + PTR_ONE;
      redirect_valid_d = 1'b1;
      redirect_pc_d    = is_jalr_q[resolve_tag] ? resolve_target : pc_q[resolve_tag];
    end
    if (alloc_fire) begin
      valid_d[tail_idx]    = 1'b1;
      resolved_d[tail_idx] = 1'b0;
      tail_d               = tail_q + PTR_ONE;
    end
  end

  // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      valid_q          <= '0;
      resolved_q       <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      valid_q          <= valid_d;
      resolved_q       <= resolved_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // NOTE: payload storage is not reset; it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_idx]      <= alloc_recovery_pc;
      is_jalr_q[tail_idx] <= alloc_is_jalr;
    end
  end

  assign alloc_tag      = tail_idx;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign occupancy      = occ;
  assign empty          = occ == '0;

`ifdef BTQ_STATS_EN
  logic [31:0] stat_res_q, stat_res_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_res_d = stat_res_q;
    stat_mp_d  = stat_mp_q;
    if (rs_accept && stat_res_q != '1) stat_res_d = stat_res_q + 32'd1;
    if (mp_accept && stat_mp_q  != '1) stat_mp_d  = stat_mp_q  + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_res_q <= '0;
      stat_mp_q  <= '0;
    end else begin
      stat_res_q <= stat_res_d;
      stat_mp_q  <= stat_mp_d;
    end
  end

  assign stat_resolved   = stat_res_q;
  assign stat_mispredict = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_tag_queue.sv
// Self-checking bench for branch_tag_queue (DEPTH=8): directed scenarios plus a random
// run compared against an ordered-list reference model.
module tb_branch_tag_queue;
  localparam int D = 8;
  localparam int X = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_valid = 1'b0, alloc_is_jalr = 1'b0;
  logic [X-1:0]  alloc_recovery_pc = '0;
  logic          alloc_ready;
  logic [2:0]    alloc_tag;
  logic          resolve_valid = 1'b0, resolve_mispredict = 1'b0;
  logic [2:0]    resolve_tag = '0;
  logic [X-1:0]  resolve_target = '0;
  logic          redirect_valid;
  logic [X-1:0]  redirect_pc;
  logic [3:0]    occupancy;
  logic          empty;

  int checks = 0;
  int errors = 0;

  branch_tag_queue #(.DEPTH(D), .XLEN(X)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_is_jalr(alloc_is_jalr),
    .alloc_recovery_pc(alloc_recovery_pc), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
    .resolve_mispredict(resolve_mispredict), .resolve_target(resolve_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .occupancy(occupancy), .empty(empty)
  );

  always #5 clk = ~clk;

  // Reference model: live entries oldest-first; tag of entry i is (m_head + i) mod D.
  typedef struct { logic jalr; logic [X-1:0] pc; bit resolved; } ent_t;
  ent_t         mq[$];
  int           m_head = 0;
  bit           m_redir = 0;
  logic [X-1:0] m_redir_pc = '0;

  bit           obs_ready, exp_ready;
  logic [2:0]   obs_tag, exp_tag;

  function automatic int m_find(input logic [2:0] tag);
    for (int i = 0; i < mq.size(); i++)
      if (((m_head + i) % D) == int'(tag)) return i;
    return -1;
  endfunction

  function automatic bit m_ready(input bit rv, input logic [2:0] rt, input bit rm);
    return (mq.size() < D) && !(rv && rm && m_find(rt) >= 0) && !m_redir;
  endfunction

  task automatic m_step(input bit r, input bit av, input bit aj, input logic [X-1:0] apc,
                        input bit rv, input logic [2:0] rt, input bit rm,
                        input logic [X-1:0] rtg);
    bit rdy, ret, nred;
    int k;
    ent_t e;
    if (r) begin
      mq.delete(); m_head = 0; m_redir = 0; m_redir_pc = '0;
      return;
    end
    rdy  = m_ready(rv, rt, rm);
    ret  = (mq.size() > 0) && mq[0].resolved;
    k    = m_find(rt);
    nred = 0;
    if (rv && k >= 0 && !mq[k].resolved) begin
      mq[k].resolved = 1;
      if (rm) begin
        nred = 1;
        m_redir_pc = mq[k].jalr ? rtg : mq[k].pc;
        while (mq.size() > k + 1) void'(mq.pop_back());
      end
    end
    if (ret) begin
      void'(mq.pop_front());
      m_head = (m_head + 1) % (2 * D);
    end
    if (av && rdy) begin
      e.jalr = aj; e.pc = apc; e.resolved = 0;
      mq.push_back(e);
    end
    m_redir = nred;
  endtask

  // One clock of stimulus; snapshots combinational outputs before the edge.
  task automatic cycle(input bit r, input bit av, input bit aj, input logic [X-1:0] apc,
                       input bit rv, input logic [2:0] rt, input bit rm,
                       input logic [X-1:0] rtg);
    rst = r; alloc_valid = av; alloc_is_jalr = aj; alloc_recovery_pc = apc;
    resolve_valid = rv; resolve_tag = rt; resolve_mispredict = rm; resolve_target = rtg;
    #1;
    obs_ready = alloc_ready; obs_tag = alloc_tag;
    exp_ready = m_ready(rv, rt, rm);
    exp_tag   = 3'((m_head + mq.size()) % D);
    @(posedge clk);
    m_step(r, av, aj, apc, rv, rt, rm, rtg);
    #1;
    rst = 0; alloc_valid = 0; resolve_valid = 0; resolve_mispredict = 0;
  endtask

  task automatic do_reset();        cycle(1, 0, 0, '0, 0, '0, 0, '0); endtask
  task automatic idle();            cycle(0, 0, 0, '0, 0, '0, 0, '0); endtask
  task automatic alloc(input bit aj, input logic [X-1:0] pc);
    cycle(0, 1, aj, pc, 0, '0, 0, '0);
  endtask
  task automatic resolve(input logic [2:0] t, input bit mp, input logic [X-1:0] tg);
    cycle(0, 0, 0, '0, 1, t, mp, tg);
  endtask

  task automatic test_reset();
    alloc(0, 32'h44); alloc(0, 32'h48); resolve(0, 1, '0);
    do_reset();
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redir got %b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== '0) begin errors++; $display("FAIL reset_redir_pc got %h exp 0", redirect_pc); end
    checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL reset_tag got %0d exp 0", alloc_tag); end
    checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", alloc_ready); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < D; i++) begin
      alloc(0, 32'h1000 + 32'(i * 4));
      checks++; if (obs_tag !== 3'(i) || obs_ready !== 1'b1) begin
        errors++; $display("FAIL fill_tag got %0d/%b exp %0d/1", obs_tag, obs_ready, i);
      end
    end
    checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL fill_occ got %0d exp 8", occupancy); end
    alloc(0, 32'h2000);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", obs_ready); end
    checks++; if (occupancy !== 4'd8 || alloc_tag !== 3'd0) begin
      errors++; $display("FAIL full_drop got occ %0d tag %0d exp 8/0", occupancy, alloc_tag);
    end
  endtask

  task automatic test_ooo_retire();
    do_reset();
    alloc(0, 32'h10); alloc(0, 32'h14); alloc(0, 32'h18);
    resolve(2, 0, '0); resolve(0, 0, '0);
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL ooo_same_cycle got %0d exp 3", occupancy); end
    idle();
    checks++; if (occupancy !== 4'd2) begin errors++; $display("FAIL ooo_head_stall got %0d exp 2", occupancy); end
    resolve(1, 0, '0); idle();
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL ooo_retire1 got %0d exp 1", occupancy); end
    idle();
    checks++; if (occupancy !== 4'd0 || empty !== 1'b1) begin
      errors++; $display("FAIL ooo_drain got occ %0d empty %b exp 0/1", occupancy, empty);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 0; i < 4; i++) alloc(0, 32'h100 + 32'(i * 4));
    resolve(1, 1, 32'hDEAD_BEEF);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL mp_block_alloc got %b exp 0", obs_ready); end
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104) begin
      errors++; $display("FAIL mp_redirect got %b/%h exp 1/00000104", redirect_valid, redirect_pc);
    end
    checks++; if (occupancy !== 4'd2 || alloc_tag !== 3'd2) begin
      errors++; $display("FAIL mp_squash got occ %0d tag %0d exp 2/2", occupancy, alloc_tag);
    end
    idle();
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL mp_redir_block got %b exp 0", obs_ready); end
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL mp_pulse got %b exp 0", redirect_valid); end
  endtask

  task automatic test_jalr();
    do_reset();
    alloc(1, 32'h200);
    resolve(0, 1, 32'h8000_0040);
    checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0040) begin
      errors++; $display("FAIL jalr_redirect got %b/%h exp 1/80000040", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) alloc(0, '0);
    for (int i = 0; i < 6; i++) resolve(3'(i), 0, '0);
    n = 0;
    while (empty !== 1'b1 && n < 10) begin idle(); n++; end
    checks++; if (empty !== 1'b1 || alloc_tag !== 3'd6) begin
      errors++; $display("FAIL wrap_drain got empty %b tag %0d exp 1/6", empty, alloc_tag);
    end
    for (int i = 0; i < 4; i++) begin
      alloc(0, 32'h300 + 32'(i * 4));
      checks++; if (obs_tag !== 3'((6 + i) % D)) begin
        errors++; $display("FAIL wrap_tag got %0d exp %0d", obs_tag, (6 + i) % D);
      end
    end
    resolve(7, 1, '0);
    checks++; if (occupancy !== 4'd2 || alloc_tag !== 3'd0 || redirect_pc !== 32'h304) begin
      errors++; $display("FAIL wrap_squash got occ %0d tag %0d pc %h exp 2/0/00000304",
                         occupancy, alloc_tag, redirect_pc);
    end
    resolve(0, 1, 32'h55);
    checks++; if (redirect_valid !== 1'b0 || occupancy !== 4'd2) begin
      errors++; $display("FAIL dead_resolve got redir %b occ %0d exp 0/2", redirect_valid, occupancy);
    end
    idle();
    checks++; if (obs_ready !== 1'b1) begin errors++; $display("FAIL wrap_reopen got %b exp 1", obs_ready); end
  endtask

  task automatic test_reset_wins();
    do_reset();
    alloc(0, 32'h400); alloc(0, 32'h404);
    cycle(1, 1, 0, 32'h408, 1, 3'd0, 1, 32'h77);
    checks++; if (redirect_valid !== 1'b0 || empty !== 1'b1 || occupancy !== 4'd0) begin
      errors++; $display("FAIL reset_wins got redir %b empty %b occ %0d exp 0/1/0",
                         redirect_valid, empty, occupancy);
    end
  endtask

  task automatic test_random();
    bit av, aj, rv, rm, r;
    logic [2:0] rt;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom % 100) == 0;
      av = ($urandom % 10) < 6;
      aj = $urandom % 2;
      rv = ($urandom % 2) == 1;
      rm = ($urandom % 5) == 0;
      if (mq.size() > 0 && ($urandom % 4) != 0)
        rt = 3'((m_head + int'($urandom % mq.size())) % D);
      else
        rt = 3'($urandom % D);
      cycle(r, av, aj, $urandom, rv, rt, rm, $urandom);
      checks++; if (obs_ready !== exp_ready || obs_tag !== exp_tag) begin
        errors++; $display("FAIL rnd_alloc c%0d got %b/%0d exp %b/%0d", c, obs_ready, obs_tag, exp_ready, exp_tag);
      end
      checks++; if (occupancy !== 4'(mq.size()) || empty !== (mq.size() == 0)) begin
        errors++; $display("FAIL rnd_occ c%0d got %0d/%b exp %0d", c, occupancy, empty, mq.size());
      end
      checks++; if (redirect_valid !== m_redir) begin
        errors++; $display("FAIL rnd_redir c%0d got %b exp %b", c, redirect_valid, m_redir);
      end
      if (m_redir) begin
        checks++; if (redirect_pc !== m_redir_pc) begin
          errors++; $display("FAIL rnd_redir_pc c%0d got %h exp %h", c, redirect_pc, m_redir_pc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_ooo_retire();
    test_mispredict();
    test_jalr();
    test_wrap();
    test_reset_wins();
    do_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
